// File: rtl/r16_out_serializer_pkg.sv
// Shared NTT constants, occupancy encoding and the 4-bit digit-reversal
// helper used by the serializer and the address generators.
package r16_out_serializer_pkg;

  localparam int R16_LANES = 16;
  localparam int R16_IDX_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Reverse the four bits of a radix-16 lane index (0,8,4,12,2,...).
  function automatic logic [R16_IDX_W-1:0] bitrev4(input logic [R16_IDX_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/r16_out_serializer_if.sv
// Handshake bundle between the butterfly (vector side) and the word sink.
interface r16_out_serializer_if
  import r16_out_serializer_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic                           in_valid;
  logic                           in_ready;
  logic [R16_LANES*DATA_W-1:0]    in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_data;
  logic [R16_IDX_W-1:0]           out_idx;
  logic                           out_last;
  logic [1:0]                     occupancy;

  // Serializer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, occupancy
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, occupancy
  );
endinterface

// File: rtl/r16_out_serializer_vec_slot.sv
// One 16-word vector slot: parallel write of a whole vector, word read by index.
module r16_vec_slot
  import r16_out_serializer_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [R16_LANES*DATA_W-1:0] wr_data,
  input  logic [R16_IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]           rd_data
);

  logic [DATA_W-1:0] lane_q [R16_LANES];

  for (genvar gi = 0; gi < R16_LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] word_reg;

    // Capture this lane's word whenever the whole vector is written.
    always_ff @(posedge clk) begin
      if (we) word_reg <= wr_data[gi*DATA_W +: DATA_W];
    end

    assign lane_q[gi] = word_reg;
  end

  assign rd_data = lane_q[rd_idx];

endmodule

// File: rtl/r16_out_serializer.sv
// Two-slot ping-pong buffer that turns radix-16 butterfly result vectors
// into a one-word-per-cycle stream, optionally in digit-reversed order.
module r16_out_serializer
  import r16_out_serializer_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter bit ORDER_REV = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  r16_out_serializer_if.slave       bus
);

  occ_e                 occ_reg, occ_next;
  logic                 wr_ptr_reg, wr_ptr_next;
  logic                 rd_ptr_reg, rd_ptr_next;
  logic [R16_IDX_W-1:0] cnt_reg, cnt_next;
  logic [R16_IDX_W-1:0] rd_idx;
  logic                 in_ready_int, out_valid_int;
  logic                 accept, fire, rel_vec;
  logic [DATA_W-1:0]    slot_rd [2];

  // Handshake flags depend only on registered state, so in_ready never
  // sees out_ready combinationally and out_* never sees in_*.
  assign in_ready_int  = (occ_reg != FULL);
  assign out_valid_int = (occ_reg != EMPTY);
  assign accept        = bus.in_valid & in_ready_int;
  assign fire          = out_valid_int & bus.out_ready;
  assign rel_vec       = fire & (cnt_reg == 4'd15);

  assign rd_idx = ORDER_REV ? bitrev4(cnt_reg) : cnt_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    r16_vec_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .we      (accept && (wr_ptr_reg == 1'(gi))),
      .wr_data (bus.in_data),
      .rd_idx  (rd_idx),
      .rd_data (slot_rd[gi])
    );
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_idx   = rd_idx;
  assign bus.out_last  = (cnt_reg == 4'd15);
  // Slots are not reset; gating keeps out_data at zero while nothing is buffered.
  assign bus.out_data  = out_valid_int ? slot_rd[rd_ptr_reg] : '0;
  assign bus.occupancy = occ_reg;

  // Next-state for occupancy, pointers and word counter.
  always_comb begin
    occ_next    = occ_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;

    if (accept) wr_ptr_next = ~wr_ptr_reg;
    if (fire)   cnt_next    = cnt_reg + 4'd1;
    if (rel_vec) rd_ptr_next = ~rd_ptr_reg;

    unique case (occ_reg)
      EMPTY:   if (accept) occ_next = ONE;
      ONE: begin
        if (accept && !rel_vec)      occ_next = FULL;
        else if (!accept && rel_vec) occ_next = EMPTY;
      end
      FULL:    if (rel_vec && !accept) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  // State register; reset drops every buffered vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg    <= EMPTY;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      occ_reg    <= occ_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_r16_out_serializer.sv
// Bench for r16_out_serializer: natural and digit-reversed instances share
// one stimulus stream and are checked against a vector-queue reference model.
module tb_r16_out_serializer;
  localparam int DW = 64;
  localparam int VW = 16 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r16_out_serializer_if #(.DATA_W(DW)) bus0 ();
  r16_out_serializer_if #(.DATA_W(DW)) bus1 ();

  r16_out_serializer #(.DATA_W(DW), .ORDER_REV(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  r16_out_serializer #(.DATA_W(DW), .ORDER_REV(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic          in_valid_d  = 1'b0;
  logic [VW-1:0] in_data_d   = '0;
  logic          out_ready_d = 1'b0;

  assign bus0.in_valid  = in_valid_d;
  assign bus0.in_data   = in_data_d;
  assign bus0.out_ready = out_ready_d;
  assign bus1.in_valid  = in_valid_d;
  assign bus1.in_data   = in_data_d;
  assign bus1.out_ready = out_ready_d;

  // Emission order for the digit-reversed instance.
  int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [VW-1:0] model_q [$];   // vectors held by the serializer, oldest first
  logic [VW-1:0] pend_q  [$];   // vectors the source still has to offer
  int            pos      = 0;  // words of model_q[0] already emitted
  int            n_vec    = 0;
  bit            last_acc = 1'b0;
  int            n_cmp    = 0;
  int            n_bad    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] make_vec(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = 64'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = {$urandom, $urandom};
    return v;
  endfunction

  // One clock: compare both DUTs with the model, then advance the model.
  task automatic cycle();
    int            nq;
    logic [VW-1:0] cur;
    int            k1;
    bit            acc, fire;
    nq = model_q.size();
    check_val("occ0", 64'(bus0.occupancy), 64'(nq));
    check_val("occ1", 64'(bus1.occupancy), 64'(nq));
    check_val("in_ready", 64'(bus0.in_ready), 64'(nq < 2));
    check_val("out_valid0", 64'(bus0.out_valid), 64'(nq > 0));
    check_val("out_valid1", 64'(bus1.out_valid), 64'(nq > 0));
    if (nq > 0) begin
      cur = model_q[0];
      k1  = rev_tab[pos];
      check_val("data0", bus0.out_data, cur[pos*DW +: DW]);
      check_val("idx0", 64'(bus0.out_idx), 64'(pos));
      check_val("last0", 64'(bus0.out_last), 64'(pos == 15));
      check_val("data1", bus1.out_data, cur[k1*DW +: DW]);
      check_val("idx1", 64'(bus1.out_idx), 64'(k1));
      check_val("last1", 64'(bus1.out_last), 64'(pos == 15));
    end
    acc  = in_valid_d && (nq < 2) && !rst;
    fire = (nq > 0) && out_ready_d && !rst;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      pos = 0;
    end else begin
      if (fire) begin
        pos++;
        if (pos == 16) begin
          pos = 0;
          void'(model_q.pop_front());
          n_vec++;
          $display("vector %0d drained", n_vec);
        end
      end
      if (acc) model_q.push_back(in_data_d);
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  // Drive source/sink for one cycle. rmode: 0 stall, 1 ready, 2 random.
  task automatic step(input int rmode, input int gap_pct);
    if (!in_valid_d && pend_q.size() > 0 && ($urandom_range(99) >= 32'(gap_pct))) begin
      in_valid_d = 1'b1;
      in_data_d  = pend_q.pop_front();
    end else if (!in_valid_d) begin
      in_data_d = rand_vec();   // junk that must never be captured
    end
    out_ready_d = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
    cycle();
    if (last_acc) in_valid_d = 1'b0;
  endtask

  task automatic run(input int n, input int rmode);
    for (int i = 0; i < n; i++) step(rmode, 0);
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values.
    check_val("rst_data", bus0.out_data, 64'd0);
    check_val("rst_idx", 64'(bus0.out_idx), 64'd0);
    check_val("rst_last", 64'(bus0.out_last), 64'd0);

    // Single vector, word k = k+1.
    pend_q.push_back(make_vec(1));
    run(20, 1);

    // Back-to-back A and B.
    pend_q.push_back(make_vec(100));
    pend_q.push_back(make_vec(150));
    run(36, 1);

    // Backpressure with three vectors offered.
    pend_q.push_back(make_vec(100));
    pend_q.push_back(make_vec(150));
    pend_q.push_back(make_vec(200));
    run(20, 0);
    check_val("bp_occ", 64'(bus0.occupancy), 64'd2);
    check_val("bp_in_ready", 64'(bus0.in_ready), 64'd0);
    check_val("bp_data", bus0.out_data, 64'd100);
    check_val("bp_idx", 64'(bus0.out_idx), 64'd0);
    check_val("bp_src_hold", 64'(in_valid_d), 64'd1);
    run(52, 1);

    // Random traffic: 64 vectors, 50% out_ready, random source gaps.
    for (int v = 0; v < 64; v++) pend_q.push_back(rand_vec());
    guard = 0;
    while ((pend_q.size() > 0 || in_valid_d || model_q.size() > 0) && guard < 5000) begin
      step(2, 25);
      guard++;
    end
    check_val("drain_timeout", 64'(guard >= 5000), 64'd0);

    // Reset while vector A is on word 7.
    pend_q.push_back(make_vec(100));
    guard = 0;
    do begin
      step(1, 0);
      guard++;
    end while (!(model_q.size() > 0 && pos == 7) && guard < 50);
    check_val("reach_idx7", 64'(guard >= 50), 64'd0);
    rst = 1'b1;
    in_valid_d = 1'b0;
    pend_q.delete();
    cycle();
    rst = 1'b0;
    check_val("post_rst_valid", 64'(bus0.out_valid), 64'd0);
    check_val("post_rst_occ", 64'(bus0.occupancy), 64'd0);
    check_val("post_rst_ready", 64'(bus0.in_ready), 64'd1);
    pend_q.push_back(make_vec(40));
    run(20, 1);
    check_val("final_vec_count", 64'(n_vec), 64'd71);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
